// File: rtl/pipe_shifter.sv
//-----------------------------------------------------------------------------
// pipe_shifter
//
// Pipelined shift/rotate unit. Each operation passes through one log-shifter
// stage per cycle. Stage k moves the operand by 2^k positions when bit k of
// the shift amount is set. A registered output stage follows the last shifter
// stage. All stages and the output register share a single advance enable,
// so a stalled consumer freezes the whole pipe and blocks new input.
//
// Parameters:
//   WIDTH   data width; power of two, 4..64
//   SHW     $clog2(WIDTH); shift-amount width and number of shifter stages
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset; empties the pipe
//   in_valid   in   operation offered
//   in_ready   out  operation accepted when in_valid && in_ready
//   in_data    in   operand
//   in_amt     in   shift amount, 0..WIDTH-1
//   in_op      in   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  out  result available
//   out_ready  in   result consumed when out_valid && out_ready
//   out_data   out  result
//   out_carry  out  last bit moved out (0 for a zero amount)
//   out_zero   out  out_data == 0
//
// Build option:
//   PIPE_SHIFTER_ROTATE_EN  when defined, op 11 rotates right; otherwise the
//                           wrap logic is left out and op 11 behaves as SRL.
//-----------------------------------------------------------------------------
module pipe_shifter #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // One shifter step by a fixed distance sh (1 <= sh < WIDTH).
    // Returns {carry, data}; carry is the last bit moved out by this step.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input int               sh
    );
        logic [WIDTH-1:0] w_hi_out;
        logic [WIDTH-1:0] w_lo_out;
        logic [WIDTH-1:0] w_res;
        logic             w_cy;
        // bit 0 of these holds d[WIDTH-sh] and d[sh-1] respectively
        w_hi_out = d >> (WIDTH - sh);
        w_lo_out = d >> (sh - 1);
        case (op)
            OP_SLL: begin
                w_res = d << sh;
                w_cy  = w_hi_out[0];
            end
            OP_SRA: begin
                w_res = $signed(d) >>> sh;
                w_cy  = w_lo_out[0];
            end
`ifdef PIPE_SHIFTER_ROTATE_EN
            OP_ROR: begin
                // the bit wrapped into the MSB is the last one moved out
                w_res = (d >> sh) | (d << (WIDTH - sh));
                w_cy  = w_lo_out[0];
            end
`endif
            default: begin
                // SRL, and ROR when rotate support is not built
                w_res = d >> sh;
                w_cy  = w_lo_out[0];
            end
        endcase
        return {w_cy, w_res};
    endfunction

    logic w_en;

    // Shifter stage registers. op/amt are only needed by later stages, so the
    // last stage does not carry them.
    logic             r_vld_p  [SHW];
    logic [WIDTH-1:0] r_data_p [SHW];
    logic             r_cy_p   [SHW];
    logic [1:0]       r_op_p   [SHW-1];
    logic [SHW-1:0]   r_amt_p  [SHW-1];

    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_cy;

    // Everything advances together unless a valid result is waiting on a
    // consumer that is not ready.
    assign w_en     = !r_out_vld || out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic             w_vld_in;
        logic [WIDTH-1:0] w_data_in;
        logic [1:0]       w_op_in;
        logic             w_cy_in;
        logic             w_amt_bit;
        logic [WIDTH:0]   w_step;

        // ---- stage k input: from the ports for k=0, else from stage k-1 ----
        if (k == 0) begin : g_first
            assign w_vld_in  = in_valid;
            assign w_data_in = in_data;
            assign w_op_in   = in_op;
            assign w_cy_in   = 1'b0;
            assign w_amt_bit = in_amt[0];
        end else begin : g_next
            assign w_vld_in  = r_vld_p[k-1];
            assign w_data_in = r_data_p[k-1];
            assign w_op_in   = r_op_p[k-1];
            assign w_cy_in   = r_cy_p[k-1];
            assign w_amt_bit = r_amt_p[k-1][k];
        end

        assign w_step = shift_step(w_data_in, w_op_in, 1 << k);

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_vld_p[k]  <= 1'b0;
                r_data_p[k] <= '0;
                r_cy_p[k]   <= 1'b0;
            end else if (w_en) begin
                r_vld_p[k] <= w_vld_in;
                if (w_amt_bit) begin
                    r_data_p[k] <= w_step[WIDTH-1:0];
                    r_cy_p[k]   <= w_step[WIDTH];
                end else begin
                    r_data_p[k] <= w_data_in;
                    r_cy_p[k]   <= w_cy_in;
                end
            end
        end

        if (k < SHW - 1) begin : g_ctl
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_op_p[k]  <= OP_SLL;
                    r_amt_p[k] <= '0;
                end else if (w_en) begin
                    r_op_p[k] <= w_op_in;
                    if (k == 0) begin
                        r_amt_p[k] <= in_amt;
                    end else begin
                        r_amt_p[k] <= r_amt_p[k-1];
                    end
                end
            end
        end
    end

    // ---- output stage: registered copy of the last shifter stage ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_cy   <= 1'b0;
        end else if (w_en) begin
            r_out_vld  <= r_vld_p[SHW-1];
            r_out_data <= r_data_p[SHW-1];
            r_out_cy   <= r_cy_p[SHW-1];
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign out_carry = r_out_cy;
    assign out_zero  = (r_out_data == '0);

endmodule

// File: tb/tb_pipe_shifter.sv
module tb_pipe_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // WIDTH=8 instance
    logic       i8_valid = 1'b0, i8_ready;
    logic [7:0] i8_data = '0;
    logic [2:0] i8_amt = '0;
    logic [1:0] i8_op = '0;
    logic       o8_valid, o8_ready = 1'b1;
    logic [7:0] o8_data;
    logic       o8_carry, o8_zero;

    // WIDTH=32 instance
    logic        i32_valid = 1'b0, i32_ready;
    logic [31:0] i32_data = '0;
    logic [4:0]  i32_amt = '0;
    logic [1:0]  i32_op = '0;
    logic        o32_valid, o32_ready = 1'b1;
    logic [31:0] o32_data;
    logic        o32_carry, o32_zero;

    pipe_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(rst_n),
        .in_valid(i8_valid), .in_ready(i8_ready), .in_data(i8_data),
        .in_amt(i8_amt), .in_op(i8_op),
        .out_valid(o8_valid), .out_ready(o8_ready), .out_data(o8_data),
        .out_carry(o8_carry), .out_zero(o8_zero)
    );

    pipe_shifter #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(rst_n),
        .in_valid(i32_valid), .in_ready(i32_ready), .in_data(i32_data),
        .in_amt(i32_amt), .in_op(i32_op),
        .out_valid(o32_valid), .out_ready(o32_ready), .out_data(o32_data),
        .out_carry(o32_carry), .out_zero(o32_zero)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: result of shifting a w-bit value by s, from the op definitions.
    // Returns {carry, data}.
    function automatic logic [64:0] ref_shift(input int w, input logic [63:0] din,
                                              input int s, input logic [1:0] op);
        logic [63:0] mask, d, r;
        longint      sd;
        logic        c;
        mask = (64'd1 << w) - 64'd1;
        d    = din & mask;
        if (s == 0) return {1'b0, d};
        case (op)
            2'b00: begin
                r = (d << s) & mask;
                c = ((d >> (w - s)) & 64'd1) != 0;
            end
            2'b10: begin
                sd = d[w-1] ? $signed(d | ~mask) : $signed(d);
                r  = 64'(sd >>> s) & mask;
                c  = ((d >> (s - 1)) & 64'd1) != 0;
            end
`ifdef PIPE_SHIFTER_ROTATE_EN
            2'b11: begin
                r = ((d >> s) | (d << (w - s))) & mask;
                c = ((r >> (w - 1)) & 64'd1) != 0;
            end
`endif
            default: begin
                r = d >> s;
                c = ((d >> (s - 1)) & 64'd1) != 0;
            end
        endcase
        return {c, r};
    endfunction

    // Scoreboard state, one set per instance (0: WIDTH=8, 1: WIDTH=32)
    logic [64:0] q8[$];
    logic [64:0] q32[$];
    int          pops[2] = '{0, 0};
    logic        held[2] = '{1'b0, 1'b0};
    logic [63:0] held_data[2];
    bit          mon_on = 1'b0;

    function automatic int qsize(input int id);
        return (id == 0) ? q8.size() : q32.size();
    endfunction

    task automatic mon(input int id, input logic rn, input logic iv, input logic ir,
                       input logic [63:0] idat, input int amt, input logic [1:0] op,
                       input logic ov, input logic ordy, input logic [63:0] od,
                       input logic oc, input logic oz);
        int          w;
        string       t;
        logic [64:0] e;
        w = (id == 0) ? 8 : 32;
        t = (id == 0) ? "w8" : "w32";
        if (!rn) begin
            if (id == 0) q8.delete(); else q32.delete();
            held[id] = 1'b0;
            return;
        end
        chk({t, "_in_ready"}, 64'(ir), 64'(!(ov && !ordy)));
        chk({t, "_zero_flag"}, 64'(oz), 64'(od == 64'd0));
        if (held[id]) chk({t, "_stall_hold"}, od, held_data[id]);
        held[id]      = ov && !ordy;
        held_data[id] = od;
        if (ov) begin
            if (qsize(id) == 0) begin
                chk({t, "_stale_result"}, 64'(ov), 64'd0);
            end else if (ordy) begin
                e = (id == 0) ? q8.pop_front() : q32.pop_front();
                pops[id]++;
                chk({t, "_data"}, od, e[63:0]);
                chk({t, "_carry"}, 64'(oc), 64'(e[64]));
            end
        end
        if (iv && ir) begin
            if (id == 0) q8.push_back(ref_shift(w, idat, amt, op));
            else         q32.push_back(ref_shift(w, idat, amt, op));
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, rst_n, i8_valid, i8_ready, 64'(i8_data), int'(i8_amt), i8_op,
                o8_valid, o8_ready, 64'(o8_data), o8_carry, o8_zero);
            mon(1, rst_n, i32_valid, i32_ready, 64'(i32_data), int'(i32_amt), i32_op,
                o32_valid, o32_ready, 64'(o32_data), o32_carry, o32_zero);
        end
    end

    function automatic logic get_ready(input int id);
        return (id == 0) ? i8_ready : i32_ready;
    endfunction
    function automatic logic get_ovld(input int id);
        return (id == 0) ? o8_valid : o32_valid;
    endfunction
    function automatic logic [63:0] get_odata(input int id);
        return (id == 0) ? 64'(o8_data) : 64'(o32_data);
    endfunction
    function automatic logic get_ocarry(input int id);
        return (id == 0) ? o8_carry : o32_carry;
    endfunction
    function automatic logic get_ozero(input int id);
        return (id == 0) ? o8_zero : o32_zero;
    endfunction

    task automatic drive_in(input int id, input logic v, input logic [63:0] d,
                            input int amt, input logic [1:0] op);
        if (id == 0) begin
            i8_valid = v; i8_data = d[7:0]; i8_amt = amt[2:0]; i8_op = op;
        end else begin
            i32_valid = v; i32_data = d[31:0]; i32_amt = amt[4:0]; i32_op = op;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int id, input logic [63:0] d, input int amt, input logic [1:0] op);
        int guard = 0;
        bit acc;
        drive_in(id, 1'b1, d, amt, op);
        do begin
            @(negedge clk);
            acc = get_ready(id) && rst_n;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        chk("issue_accept", 64'(acc), 64'd1);
        drive_in(id, 1'b0, 64'd0, 0, 2'b00);
    endtask

    // Single op into an empty pipe with out_ready=1: latency and value checks.
    task automatic run_dir(input int id, input string tag, input logic [63:0] d, input int amt,
                           input logic [1:0] op, input logic [63:0] exp_d, input logic exp_c,
                           input int exp_lat);
        int lat = 0;
        issue(id, d, amt, op);
        while (!get_ovld(id) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, get_odata(id), exp_d);
        chk({tag, "_carry"}, 64'(get_ocarry(id)), 64'(exp_c));
        chk({tag, "_zero"}, 64'(get_ozero(id)), 64'(exp_d == 64'd0));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int id, input string tag);
        int guard = 0;
        while ((qsize(id) != 0 || get_ovld(id)) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk({tag, "_drained"}, 64'(qsize(id)), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_w8_out_valid"}, 64'(o8_valid), 64'd0);
        chk({tag, "_w8_out_data"}, 64'(o8_data), 64'd0);
        chk({tag, "_w8_out_carry"}, 64'(o8_carry), 64'd0);
        chk({tag, "_w8_out_zero"}, 64'(o8_zero), 64'd1);
        chk({tag, "_w8_in_ready"}, 64'(i8_ready), 64'd1);
        chk({tag, "_w32_out_valid"}, 64'(o32_valid), 64'd0);
        chk({tag, "_w32_out_data"}, 64'(o32_data), 64'd0);
        chk({tag, "_w32_out_zero"}, 64'(o32_zero), 64'd1);
    endtask

    bit done8 = 1'b0, done32 = 1'b0;

    task automatic rand_drive(input int id, input int n);
        int w;
        w = (id == 0) ? 8 : 32;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            issue(id, {$urandom, $urandom}, $urandom_range(0, w - 1), 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops_before;
        logic [63:0] bp_d[5];

        // Reset: in_ready must already be high while reset is held
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n  = 1'b1;
        mon_on = 1'b1;
        @(posedge clk);
        #1;

        // Directed values, WIDTH=8
        run_dir(0, "sll96", 64'h96, 1, 2'b00, 64'h2C, 1'b1, 3);
        run_dir(0, "sra81_1", 64'h81, 1, 2'b10, 64'hC0, 1'b1, 3);
        run_dir(0, "sra81_7", 64'h81, 7, 2'b10, 64'hFF, 1'b0, 3);
`ifdef PIPE_SHIFTER_ROTATE_EN
        run_dir(0, "ror01", 64'h01, 1, 2'b11, 64'h80, 1'b1, 3);
`else
        run_dir(0, "ror01", 64'h01, 1, 2'b11, 64'h00, 1'b1, 3);
`endif
        run_dir(0, "srl00_0", 64'h00, 0, 2'b01, 64'h00, 1'b0, 3);
        run_dir(0, "sll5a_0", 64'h5A, 0, 2'b00, 64'h5A, 1'b0, 3);
        run_dir(0, "srl80_7", 64'h80, 7, 2'b01, 64'h01, 1'b0, 3);

        // Directed values, WIDTH=32
        run_dir(1, "w32_sra", 64'h8000_0001, 31, 2'b10, 64'hFFFF_FFFF, 1'b0, 5);
        run_dir(1, "w32_sll", 64'h9600_0001, 1, 2'b00, 64'h2C00_0002, 1'b1, 5);
        run_dir(1, "w32_sll31", 64'h0000_0003, 31, 2'b00, 64'h8000_0000, 1'b1, 5);

        // Backpressure: 5 back-to-back ops, consumer stalls for 6 cycles
        bp_d = '{64'h11, 64'hF0, 64'h3C, 64'h81, 64'h7E};
        pops_before = pops[0];
        fork
            begin
                for (int i = 0; i < 5; i++) issue(0, bp_d[i], i + 1, 2'(i % 3));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                o8_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                o8_ready = 1'b1;
            end
        join
        drain(0, "bp");
        chk("bp_result_count", 64'(pops[0] - pops_before), 64'd5);

        // Reset with 3 ops in flight
        pops_before = pops[0];
        for (int i = 0; i < 3; i++) issue(0, 64'hA5 + 64'(i), 1, 2'b01);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", 64'(o8_valid), 64'd0);
        chk("midrst_out_data", 64'(o8_data), 64'd0);
        chk("midrst_out_zero", 64'(o8_zero), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_result", 64'(pops[0] - pops_before), 64'd0);

        // Randomized traffic with random consumer stalls on both widths
        fork
            begin rand_drive(0, 250); done8 = 1'b1; end
            begin
                while (!done8) begin
                    o8_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                o8_ready = 1'b1;
            end
            begin rand_drive(1, 150); done32 = 1'b1; end
            begin
                while (!done32) begin
                    o32_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                o32_ready = 1'b1;
            end
        join
        drain(0, "rand_w8");
        drain(1, "rand_w32");

        // Final idle state after a reset
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle_outputs("final_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_shifter.md
# pipe_shifter

Parametrised, pipelined shift/rotate unit for the datapath: the next generation of the 8-bit combinational shifter. It generalises data width, adds a rotate mode, and adds carry/zero flags. Operations flow through one log-shifter stage per cycle with a valid/ready handshake on both sides. It sits between operand fetch and writeback, so the ALU can issue one shift per cycle at any width without lengthening the critical path.

## Interface
- WIDTH, 8, data width; power of two, 4..64
- SHW, $clog2(WIDTH), derived shift-amount width and stage count; not overridable
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted on edges where in_valid && in_ready
- in_data  in  WIDTH  operand
- in_amt  in  SHW  shift amount, unsigned 0..WIDTH-1
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  out  1  result available
- out_ready  in  1  result consumed on edges where out_valid && out_ready
- out_data  out  WIDTH  result
- out_carry  out  1  last bit shifted out (see Operation)
- out_zero  out  1  out_data == 0

## Operation
- The pipeline has SHW stage registers.
  - Stage k (k = 0..SHW-1) holds valid, data, op, the remaining amount bits, and carry.
  - Stage k shifts or rotates by 2^k when amt[k]=1; otherwise it passes the data through.
- Fill bits:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with copies of the data MSB, data treated as signed.
  - ROR wraps bits from the LSB end into the MSB end.
- Carry:
  - Carry enters stage 0 as 0.
  - Each active stage overwrites it with the last bit that stage moved out.
  - SLL by s gives in_data[WIDTH-s].
  - SRL/SRA by s gives in_data[s-1].
  - ROR gives result[WIDTH-1].
  - Amount 0 gives carry 0 for every op.
- out_zero is computed combinationally from the final stage data.
- Global enable en = !out_valid || out_ready.
  - in_ready = en.
  - When en=1, all stages advance one position.
  - When en=0, all stages hold and no input is accepted.
- Bubbles (in_valid=0 while en=1) propagate as valid=0. Results leave in issue order; none are dropped or duplicated.
- No state machine beyond the valid shift chain. Throughput is 1 op/cycle when out_ready is held high.

## Timing
- Latency: an op accepted at edge N appears on out_* after edge N+SHW (3 cycles for WIDTH=8).
- out_data, out_carry and out_zero are registered from the last stage. out_zero has one gate level after the register.
- While out_valid=1 && out_ready=0, out_* is stable and in_ready=0 in the same cycle (combinational from out_ready).
- Reset:
  - reset_n=0 at an edge clears every stage valid, data and carry.
  - After that edge: out_valid=0, out_data=0, out_carry=0, out_zero=1.
  - in_ready=1 whenever out_valid=0, including during reset.
  - Inputs presented while reset_n=0 are discarded.
  - Reset mid-stream drops all in-flight ops; no partial result emerges.
- Simultaneous out-handshake and in-handshake on the same edge is legal and is the steady-state case.

## Configuration
- PIPE_SHIFTER_ROTATE_EN defined:
  - op 11 performs ROR as specified.
- PIPE_SHIFTER_ROTATE_EN undefined:
  - No rotate wrap logic is built.
  - op 11 decodes as SRL: zero fill, SRL carry rule.
  - All other ops and all timing are unchanged.

## Test plan
- SLL, WIDTH=8: in_data=8'h96, amt=1, out_ready=1 -> out_data=8'h2C, carry=1, zero=0, out_valid exactly 3 cycles after accept.
- SRA: in_data=8'h81, amt=1 -> 8'hC0, carry=1. Then in_data=8'h81, amt=7 -> 8'hFF, carry=0.
- ROR: in_data=8'h01, amt=1 -> 8'h80, carry=1 with PIPE_SHIFTER_ROTATE_EN. The same stimulus without the macro -> 8'h00, carry=1, zero=1.
- Amount 0 and zero flag: SRL 8'h00 by 0 -> 8'h00, carry=0, zero=1. SLL 8'h5A by 0 -> 8'h5A, carry=0.
- Backpressure: issue 5 back-to-back ops, hold out_ready=0 from cycle 2 for 6 cycles, then release. Required:
  - in_ready low exactly while out_valid && !out_ready.
  - out_data stable during the stall.
  - All 5 results in order, no duplicates.
- Reset mid-stream, plus WIDTH=32:
  - Assert reset_n=0 for one edge with 3 ops in flight -> out_valid=0, out_data=0, zero=1 next cycle, and no stale result ever appears.
  - Rerun the SLL/SRA checks at WIDTH=32: 32'h8000_0001 SRA by 31 -> 32'hFFFF_FFFF, carry=0, latency 5.
